// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimator control sequencer.
package me_pkg;

   // Default block-size exponent; N PEs serve an N x N block.
   localparam int LOGN    = 4;
   localparam int N       = 2 ** LOGN;

   // Derived widths: reference address, search coordinate, count register.
   localparam int ADDR_W  = 2 * LOGN;
   localparam int COORD_W = LOGN + 1;
   localparam int CNT_W   = 3 * LOGN + 1;

   // Pixels per block and the last count value of a full search.
   localparam int NN      = N * N;
   localparam int T_END   = N * N * N + N - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/me_addr_gen.sv
// Splits a count value into (vy, i, k) and forms the search-window row/column.
// The window flag is low once the count has passed the last vy position.
module me_addr_gen
   import me_pkg::*;
#(
   parameter int LOGN    = me_pkg::LOGN,
   parameter int COL_OFS = 0
) (
   input  logic [3*LOGN:0]   cnt_i,
   output logic [LOGN:0]     vy_o,
   output logic [LOGN-1:0]   i_o,
   output logic [LOGN-1:0]   k_o,
   output logic [LOGN:0]     row_o,
   output logic [LOGN:0]     col_o,
   output logic              in_win_o
);

   assign vy_o     = cnt_i[3*LOGN:2*LOGN];
   assign i_o      = cnt_i[2*LOGN-1:LOGN];
   assign k_o      = cnt_i[LOGN-1:0];
   assign in_win_o = ~cnt_i[3*LOGN];
   assign row_o    = vy_o + {1'b0, i_o};
   assign col_o    = {1'b0, k_o} + (LOGN+1)'(COL_OFS);

endmodule

// File: rtl/me_control.sv
// Full-search motion estimator sequencer: walks the count t through one search,
// drives reference/search addresses and per-PE controls, and tags results.
// Every output is registered from the next (state, t) so it lines up with t.
module me_control
   import me_pkg::*;
#(
   parameter int LOGN = me_pkg::LOGN
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [2*LOGN-1:0]    AddressR,
   output logic [LOGN:0]        S1Row,
   output logic [LOGN:0]        S1Col,
   output logic [LOGN:0]        S2Row,
   output logic [LOGN:0]        S2Col,
   output logic [2**LOGN-1:0]   S1S2mux,
   output logic [2**LOGN-1:0]   newDist,
   output logic                 ResultValid,
   output logic [LOGN-1:0]      ResultSel,
   output logic [LOGN-1:0]      VecX,
   output logic [LOGN-1:0]      VecY
);

   localparam int NP = 2 ** LOGN;
   localparam int CW = 3 * LOGN + 1;
   localparam logic [CW-1:0] T_END_C = CW'(NP * NP * NP + NP - 1);
   localparam logic [CW-1:0] N_C     = CW'(NP);

   state_e          state_q, state_d;
   logic [CW-1:0]   t_q, t_d;
   logic [CW-1:0]   tp_s;
   logic [CW-1:0]   diff_s;

   logic [LOGN:0]   s1_vy, s1_row, s1_col, s2_vy, s2_row, s2_col, vym1_s;
   logic [LOGN-1:0] s1_i, s1_k, s2_i, s2_k;
   logic            s1_in, s2_in;
   logic            unused_s;

   logic                busy_d, done_d, rv_d;
   logic [2*LOGN-1:0]   addr_d;
   logic [LOGN:0]       s1r_d, s1c_d, s2r_d, s2c_d;
   logic [NP-1:0]       mux_d, nd_d;
   logic [LOGN-1:0]     sel_d, vx_d, vy_d;

   logic                busy_q, done_q, rv_q;
   logic [2*LOGN-1:0]   addr_q;
   logic [LOGN:0]       s1r_q, s1c_q, s2r_q, s2c_q;
   logic [NP-1:0]       mux_q, nd_q;
   logic [LOGN-1:0]     sel_q, vx_q, vy_q;

   // Port 2 trails port 1 by one block row (N counts).
   assign tp_s = t_d - N_C;

   me_addr_gen #(.LOGN(LOGN), .COL_OFS(0)) u_gen_s1 (
      .cnt_i(t_d), .vy_o(s1_vy), .i_o(s1_i), .k_o(s1_k),
      .row_o(s1_row), .col_o(s1_col), .in_win_o(s1_in)
   );

   me_addr_gen #(.LOGN(LOGN), .COL_OFS(NP)) u_gen_s2 (
      .cnt_i(tp_s), .vy_o(s2_vy), .i_o(s2_i), .k_o(s2_k),
      .row_o(s2_row), .col_o(s2_col), .in_win_o(s2_in)
   );

   // Result rows belong to the previous vy pass.
   assign vym1_s   = s1_vy - (LOGN+1)'(1);
   assign unused_s = ^{s1_i, s2_vy, s2_i, s2_k, vym1_s[LOGN]};

   // State and count register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         t_q     <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
      end
   end

   // Next state and next count: t restarts at 0 on every entry to RUN.
   always_comb begin
      state_d = state_q;
      t_d     = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (t_q == T_END_C) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
               t_d     = t_q + CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output values for the coming cycle, derived from (state_d, t_d).
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      rv_d   = 1'b0;
      addr_d = '0;
      s1r_d  = '0;
      s1c_d  = '0;
      s2r_d  = '0;
      s2c_d  = '0;
      mux_d  = '0;
      nd_d   = '0;
      sel_d  = '0;
      vx_d   = '0;
      vy_d   = '0;
      diff_s = '0;
      if (state_d == RUN) begin
         busy_d = 1'b1;
         addr_d = t_d[2*LOGN-1:0];
         if (s1_in) begin
            s1r_d = s1_row;
            s1c_d = s1_col;
         end else begin
            s1r_d = '0;
            s1c_d = '0;
         end
         if ((t_d >= N_C) && s2_in) begin
            s2r_d = s2_row;
            s2c_d = s2_col;
         end else begin
            s2r_d = '0;
            s2c_d = '0;
         end
         for (int j = 0; j < NP; j++) begin
            mux_d[j] = (s1_k >= LOGN'(j));
            diff_s   = t_d - CW'(j);
            nd_d[j]  = (t_d >= CW'(j)) && (diff_s[2*LOGN-1:0] == '0)
                       && !diff_s[CW-1];
         end
         if ((t_d[CW-1:2*LOGN] != '0) && (t_d[2*LOGN-1:LOGN] == '0)) begin
            rv_d  = 1'b1;
            sel_d = s1_k;
            vx_d  = s1_k;
            vy_d  = vym1_s[LOGN-1:0];
         end else begin
            rv_d  = 1'b0;
         end
      end else if (state_d == DONE) begin
         done_d = 1'b1;
      end else begin
         done_d = 1'b0;
      end
   end

   // Output registers; reset returns every output to zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         rv_q   <= 1'b0;
         addr_q <= '0;
         s1r_q  <= '0;
         s1c_q  <= '0;
         s2r_q  <= '0;
         s2c_q  <= '0;
         mux_q  <= '0;
         nd_q   <= '0;
         sel_q  <= '0;
         vx_q   <= '0;
         vy_q   <= '0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         rv_q   <= rv_d;
         addr_q <= addr_d;
         s1r_q  <= s1r_d;
         s1c_q  <= s1c_d;
         s2r_q  <= s2r_d;
         s2c_q  <= s2c_d;
         mux_q  <= mux_d;
         nd_q   <= nd_d;
         sel_q  <= sel_d;
         vx_q   <= vx_d;
         vy_q   <= vy_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign ResultValid = rv_q;
   assign AddressR    = addr_q;
   assign S1Row       = s1r_q;
   assign S1Col       = s1c_q;
   assign S2Row       = s2r_q;
   assign S2Col       = s2c_q;
   assign S1S2mux     = mux_q;
   assign newDist     = nd_q;
   assign ResultSel   = sel_q;
   assign VecX        = vx_q;
   assign VecY        = vy_q;

endmodule

// File: tb/tb_me_control.sv
// Bench for me_control at N=4: arithmetic reference model, directed table,
// corner-case sequences and randomized start/reset traffic.
module tb_me_control;

   localparam int LOGN  = 2;
   localparam int N     = 4;
   localparam int NN    = 16;
   localparam int N3    = 64;
   localparam int T_END = 67;

   logic             clock, reset, start;
   logic             busy, done, ResultValid;
   logic [3:0]       AddressR;
   logic [2:0]       S1Row, S1Col, S2Row, S2Col;
   logic [3:0]       S1S2mux, newDist;
   logic [1:0]       ResultSel, VecX, VecY;

   me_control #(.LOGN(LOGN)) dut (
      .clock(clock), .reset(reset), .start(start),
      .busy(busy), .done(done), .AddressR(AddressR),
      .S1Row(S1Row), .S1Col(S1Col), .S2Row(S2Row), .S2Col(S2Col),
      .S1S2mux(S1S2mux), .newDist(newDist), .ResultValid(ResultValid),
      .ResultSel(ResultSel), .VecX(VecX), .VecY(VecY)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int busy, done, addr, s1r, s1c, s2r, s2c, mux, nd, rv, sel, vx, vy;
   } exp_t;

   typedef struct {
      int   t;
      exp_t e;
   } vec_t;

   vec_t vecs[7];
   int   nchecks = 0;
   int   nerr    = 0;
   int   ms      = 0;   // 0 idle, 1 searching, 2 done pulse
   int   mt      = 0;
   bit   use_table = 1'b0;
   int   hits    = 0;

   // Expected outputs straight from the arithmetic definitions.
   function automatic exp_t model_out(int st, int t);
      exp_t e;
      int   tp;
      e = '{default:0};
      if (st == 2) e.done = 1;
      if (st == 1) begin
         e.busy = 1;
         e.addr = t % NN;
         if (t < N3) begin
            e.s1r = t / NN + (t % NN) / N;
            e.s1c = t % N;
         end
         tp = t - N;
         if (t >= N && tp < N3) begin
            e.s2r = tp / NN + (tp % NN) / N;
            e.s2c = tp % N + N;
         end
         for (int j = 0; j < N; j++) begin
            if (t % N >= j) e.mux = e.mux | (1 << j);
            if (t >= j && (t - j) % NN == 0 && (t - j) < N3) e.nd = e.nd | (1 << j);
         end
         if (t >= NN && t % NN < N) begin
            e.rv  = 1;
            e.sel = t % N;
            e.vx  = t % N;
            e.vy  = t / NN - 1;
         end
      end
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      nchecks++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (model t=%0d)", name, act, exp, mt);
      end
   endtask

   task automatic compare_all(input string tag, input exp_t e);
      chk({tag, ".busy"},    int'(busy),        e.busy);
      chk({tag, ".done"},    int'(done),        e.done);
      chk({tag, ".AddrR"},   int'(AddressR),    e.addr);
      chk({tag, ".S1Row"},   int'(S1Row),       e.s1r);
      chk({tag, ".S1Col"},   int'(S1Col),       e.s1c);
      chk({tag, ".S2Row"},   int'(S2Row),       e.s2r);
      chk({tag, ".S2Col"},   int'(S2Col),       e.s2c);
      chk({tag, ".mux"},     int'(S1S2mux),     e.mux);
      chk({tag, ".newDist"}, int'(newDist),     e.nd);
      chk({tag, ".RValid"},  int'(ResultValid), e.rv);
      chk({tag, ".RSel"},    int'(ResultSel),   e.sel);
      chk({tag, ".VecX"},    int'(VecX),        e.vx);
      chk({tag, ".VecY"},    int'(VecY),        e.vy);
   endtask

   // One clock: drive at negedge, advance model at posedge, check at next negedge.
   task automatic cycle(input logic st, input logic rs);
      start = st;
      reset = rs;
      @(posedge clock);
      if (rs) begin
         ms = 0; mt = 0;
      end else if (ms == 0) begin
         if (st) begin ms = 1; mt = 0; end
      end else if (ms == 1) begin
         if (mt == T_END) begin ms = 2; mt = 0; end
         else mt = mt + 1;
      end else begin
         ms = 0; mt = 0;
      end
      @(negedge clock);
      compare_all("model", model_out(ms, mt));
      if (use_table && ms == 1) begin
         for (int v = 0; v < 7; v++) begin
            if (vecs[v].t == mt) begin
               hits++;
               compare_all($sformatf("tbl_t%0d", mt), vecs[v].e);
            end
         end
      end
   endtask

   initial begin
      //                 busy done addr s1r s1c s2r s2c mux nd rv sel vx vy
      vecs[0] = '{0,  '{1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0}};
      vecs[1] = '{5,  '{1, 0, 5, 1, 1, 0, 5,  3, 0, 0, 0, 0, 0}};
      vecs[2] = '{16, '{1, 0, 0, 1, 0, 3, 4,  1, 1, 1, 0, 0, 0}};
      vecs[3] = '{19, '{1, 0, 3, 1, 3, 3, 7, 15, 8, 1, 3, 3, 0}};
      vecs[4] = '{20, '{1, 0, 4, 2, 0, 1, 4,  1, 0, 0, 0, 0, 0}};
      vecs[5] = '{64, '{1, 0, 0, 0, 0, 6, 4,  1, 0, 1, 0, 0, 3}};
      vecs[6] = '{67, '{1, 0, 3, 0, 0, 6, 7, 15, 0, 1, 3, 3, 3}};

      reset = 1'b1;
      start = 1'b0;
      @(negedge clock);
      cycle(1'b0, 1'b1);
      cycle(1'b1, 1'b1);               // start ignored under reset

      // Run 1: full search against the directed table.
      use_table = 1'b1;
      cycle(1'b1, 1'b0);
      for (int c = 0; c < 200 && ms != 2; c++) cycle(1'b0, 1'b0);
      use_table = 1'b0;
      chk("run1_done_pulse", int'(done), 1);
      chk("run1_done_busy",  int'(busy), 0);
      chk("table_entries_reached", hits, 7);
      cycle(1'b0, 1'b0);
      chk("run1_idle_done", int'(done), 0);

      // Run 2: start mid-run is ignored, reset mid-run aborts cleanly.
      cycle(1'b1, 1'b0);
      for (int c = 0; c < 50 && mt < 10; c++) cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      chk("start_ignored_addr", int'(AddressR), 11);
      chk("start_ignored_busy", int'(busy), 1);
      for (int c = 0; c < 50 && mt < 30; c++) cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      chk("reset_busy",    int'(busy), 0);
      chk("reset_done",    int'(done), 0);
      chk("reset_addr",    int'(AddressR), 0);
      chk("reset_newDist", int'(newDist), 0);
      cycle(1'b1, 1'b0);
      chk("restart_busy", int'(busy), 1);
      chk("restart_addr", int'(AddressR), 0);
      for (int c = 0; c < 200 && ms != 0; c++) cycle(1'b0, 1'b0);

      // Run 3: start held high across a run boundary.
      cycle(1'b1, 1'b0);
      begin : held
         int c;
         c = 0;
         while (done !== 1'b1 && c < 200) begin
            cycle(1'b1, 1'b0);
            c++;
         end
         chk("held_run_length", c, T_END + 1);
      end
      cycle(1'b1, 1'b0);
      chk("held_gap_busy", int'(busy), 0);
      chk("held_gap_done", int'(done), 0);
      cycle(1'b1, 1'b0);
      chk("held_rerun_busy", int'(busy), 1);
      chk("held_rerun_addr", int'(AddressR), 0);

      // Randomized start/reset traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         cycle(($urandom % 4) == 0, ($urandom % 100) == 0);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule

// File: doc/me_control.md
Name: me_control

Overview:
- Control and address sequencer for the full-search motion estimator. It is the initiator that drives the PE array.
- Generates the reference/search memory addresses and the per-PE S1S2mux/newDist controls.
- Tags each finished distortion with its motion vector for the downstream minimum comparator.
- Serves N PEs, N x N reference block, (2N-1) x (2N-1) search window. PE j computes vectors (vy, vx=j) for vy = 0..N-1.

Parameters:
- LOGN, 4, log2 of block size; N = 2**LOGN (16 PEs, 16x16 block by default).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin one full search; sampled only in IDLE.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse after the final result.
- AddressR  out  2*LOGN  reference memory address, row-major i*N+k.
- S1Row, S1Col  out  LOGN+1 each  search memory port 1 address.
- S2Row, S2Col  out  LOGN+1 each  search memory port 2 address.
- S1S2mux  out  N  per-PE select; bit j=1 selects S1.
- newDist  out  N  per-PE accumulator restart.
- ResultValid  out  1  one PE holds a finished distortion this cycle.
- ResultSel  out  LOGN  index of that PE.
- VecX, VecY  out  LOGN each  motion vector of that result.

Behaviour:
- States: IDLE, RUN, DONE. Count register t, width 3*LOGN+1. NN = N*N; T_END = N^3+N-1.
- IDLE: start=1 goes to RUN with t=0 next cycle. Otherwise stay in IDLE.
- RUN: t increments each cycle. After t=T_END, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in RUN and DONE.
- All outputs are registered Moore functions of (state, t). Decompose t: vy=t/NN, i=(t mod NN)/N, k=t mod N.
- AddressR = t mod NN.
- S1Row = vy+i, S1Col = k. Drive 0 when t >= N^3.
- S2 uses t' = t-N decomposed the same way: S2Row = vy'+i', S2Col = k+N. Drive 0 when t < N or t' >= N^3.
- S1S2mux[j] = 1 iff k >= j.
- newDist[j] = 1 iff t >= j, (t-j) mod NN = 0, and t-j < N^3.
- ResultValid = 1 iff t >= NN and (t mod NN) < N. In that case: ResultSel = VecX = t mod N, VecY = vy-1.
- IDLE/DONE/reset values: busy=0; all addresses, S1S2mux, newDist, ResultValid, ResultSel, Vec* = 0. done=0 except in DONE.
- Reset mid-RUN: next cycle is IDLE, t=0, all outputs at reset values. No partial done pulse.
- start held high continuously: RUN, DONE, IDLE, RUN. There is one IDLE cycle between runs.
- No arithmetic overflow is permitted. vy+i <= 2N-2 and k+N <= 2N-1 fit in LOGN+1 bits.

Decomposition:
- Package me_pkg holds:
  - LOGN and N;
  - derived widths (addr, coord, count);
  - NN and T_END constants;
  - state enum {IDLE, RUN, DONE}.
- Sub-module me_addr_gen: pure combinational map from a count value to (vy, i, k) and row/col. Instantiate it twice, once for t and once for t-N, feeding the output registers.

Test Plan (LOGN=2, N=4, NN=16, T_END=67):
- Reset, then a start pulse -> next cycle busy=1, t=0: AddressR=0, S1=(0,0), S2=(0,0), S1S2mux=0001, newDist=0001, ResultValid=0.
- At t=5 -> AddressR=5, S1=(1,1), S2=(0,5), S1S2mux=0011, newDist=0000.
- At t=16 -> newDist=0001, ResultValid=1, Sel=0, Vec=(0,0). At t=19 -> newDist=1000, Sel=3, VecY=0. At t=20 -> ResultValid=0.
- At t=64 -> S1=(0,0), newDist=0000, ResultValid=1, Sel=0, VecY=3. At t=67 -> Sel=3, VecX=3, VecY=3. Next cycle done=1, busy=0. Following cycle IDLE with done=0.
- start pulsed again at t=10 -> no effect (t=11 next). reset at t=30 -> next cycle busy=0, all outputs 0. A new start restarts at t=0 with AddressR=0.
- start held high through a full run -> after DONE, exactly one IDLE cycle, then busy=1 with t=0 again.
